// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and the row-scheduler state type.
//   MB_SIZE      pixels per row
//   PIXEL_WIDTH  bits per pixel
//   ROWS         rows per macroblock
//   ROW_W        width of a row index
//   ADDR_WIDTH   line-memory address width
//   state_e      mc_row_scheduler FSM states
package mc_pkg;

  localparam int MB_SIZE     = 4;
  localparam int PIXEL_WIDTH = 8;
  localparam int ROWS        = 4;
  localparam int ROW_W       = $clog2(ROWS);
  localparam int ADDR_WIDTH  = 10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    ISSUE,
    COLLECT,
    OUTPUT,
    DONE
  } state_e;

endpackage

// File: rtl/mc_row_skid.sv
// mc_row_skid: one-entry output register for residual rows.
//   clk, rst_n                clock, asynchronous active-low reset
//   load                      capture load_data/load_row/load_last, raise res_valid
//   load_data/row/last        residual row, its index, last-row flag
//   res_valid/res_ready       downstream handshake
//   res_data/res_row/res_last registered outputs, stable while res_valid && !res_ready
//   accept                    res_valid && res_ready this cycle
module mc_row_skid #(
  parameter int DATA_W = mc_pkg::PIXEL_WIDTH * mc_pkg::MB_SIZE,
  parameter int ROW_W  = mc_pkg::ROW_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ROW_W-1:0]  load_row,
  input  logic              load_last,
  input  logic              res_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [ROW_W-1:0]  res_row,
  output logic              res_last,
  output logic              accept
);

  assign accept = res_valid && res_ready;

  // The scheduler only loads while the entry is empty, so load never
  // collides with a pending row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_last  <= 1'b0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_data  <= load_data;
      res_row   <= load_row;
      res_last  <= load_last;
    end else if (accept) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mc_row_scheduler.sv
// mc_row_scheduler: walks one macroblock row by row through the
// motion-compensation residual datapath, one row in flight at a time.
//   clk, reset                       clock, asynchronous active-low reset
//   start, cur_base, ref_base        begin a macroblock at the given row addresses
//   busy, done                       status; done pulses once per macroblock
//   cur_rd_*/ref_rd_*                line-memory reads, 1-cycle read latency
//   mc_src_valid/ready, mc_curr_mb,
//   mc_ref_frame                     rows handed to the datapath
//   mc_dst_valid/ready, mc_residual  residual returned by the datapath
//   res_valid/ready, res_data,
//   res_row, res_last                registered residual row downstream
module mc_row_scheduler #(
  parameter int  MB_SIZE     = mc_pkg::MB_SIZE,
  parameter int  PIXEL_WIDTH = mc_pkg::PIXEL_WIDTH,
  parameter int  ROWS        = mc_pkg::ROWS,
  parameter int  ADDR_WIDTH  = mc_pkg::ADDR_WIDTH,
  localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int DATA_W      = PIXEL_WIDTH * MB_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cur_base,
  input  logic [ADDR_WIDTH-1:0] ref_base,
  output logic                  busy,
  output logic                  done,
  output logic                  cur_rd_en,
  output logic [ADDR_WIDTH-1:0] cur_rd_addr,
  input  logic [DATA_W-1:0]     cur_rd_data,
  output logic                  ref_rd_en,
  output logic [ADDR_WIDTH-1:0] ref_rd_addr,
  input  logic [DATA_W-1:0]     ref_rd_data,
  output logic                  mc_src_valid,
  input  logic                  mc_src_ready,
  output logic [DATA_W-1:0]     mc_curr_mb,
  output logic [DATA_W-1:0]     mc_ref_frame,
  input  logic                  mc_dst_valid,
  output logic                  mc_dst_ready,
  input  logic [DATA_W-1:0]     mc_residual,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_data,
  output logic [ROW_W-1:0]      res_row,
  output logic                  res_last
);

  import mc_pkg::*;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_base_q, ref_base_q;
  logic [ROW_W-1:0]      row_q;
  logic                  row_is_last;
  logic                  res_load;
  logic                  res_accept;

  assign row_is_last = (row_q == ROW_W'(ROWS - 1));
  assign res_load    = (state_q == COLLECT) && mc_dst_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Moore outputs. Addresses are driven only in READ so the
  // memory ports sit at zero otherwise; the sum wraps at 2^ADDR_WIDTH.
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    cur_rd_en    = 1'b0;
    ref_rd_en    = 1'b0;
    cur_rd_addr  = '0;
    ref_rd_addr  = '0;
    mc_src_valid = 1'b0;
    mc_dst_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = READ;
      end
      READ: begin
        busy        = 1'b1;
        cur_rd_en   = 1'b1;
        ref_rd_en   = 1'b1;
        cur_rd_addr = cur_base_q + ADDR_WIDTH'(row_q);
        ref_rd_addr = ref_base_q + ADDR_WIDTH'(row_q);
        state_d     = CAPTURE;
      end
      CAPTURE: begin
        busy    = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        busy         = 1'b1;
        mc_src_valid = 1'b1;
        if (mc_src_ready) state_d = COLLECT;
      end
      COLLECT: begin
        busy         = 1'b1;
        mc_dst_ready = 1'b1;
        if (mc_dst_valid) state_d = OUTPUT;
      end
      OUTPUT: begin
        busy = 1'b1;
        if (res_accept) state_d = res_last ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_base_q   <= '0;
      ref_base_q   <= '0;
      row_q        <= '0;
      mc_curr_mb   <= '0;
      mc_ref_frame <= '0;
    end else begin
      if ((state_q == IDLE) && start) begin
        cur_base_q <= cur_base;
        ref_base_q <= ref_base;
        row_q      <= '0;
      end
      // rd_data arrives the cycle after READ; hold it for the whole ISSUE wait.
      if (state_q == CAPTURE) begin
        mc_curr_mb   <= cur_rd_data;
        mc_ref_frame <= ref_rd_data;
      end
      if ((state_q == OUTPUT) && res_accept && !res_last) begin
        row_q <= row_q + ROW_W'(1);
      end
    end
  end

  mc_row_skid #(
    .DATA_W (DATA_W),
    .ROW_W  (ROW_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .load      (res_load),
    .load_data (mc_residual),
    .load_row  (row_q),
    .load_last (row_is_last),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_row   (res_row),
    .res_last  (res_last),
    .accept    (res_accept)
  );

endmodule

// File: tb/tb_mc_row_scheduler.sv
module tb_mc_row_scheduler;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int NROW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset, start;
  logic [AW-1:0] cur_base, ref_base;
  logic          busy, done;
  logic          cur_rd_en, ref_rd_en;
  logic [AW-1:0] cur_rd_addr, ref_rd_addr;
  logic [DW-1:0] cur_rd_data, ref_rd_data;
  logic          mc_src_valid, mc_src_ready;
  logic [DW-1:0] mc_curr_mb, mc_ref_frame;
  logic          mc_dst_valid, mc_dst_ready;
  logic [DW-1:0] mc_residual;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic [1:0]    res_row;
  logic          res_last;

  mc_row_scheduler dut (
    .clk(clk), .reset(reset), .start(start),
    .cur_base(cur_base), .ref_base(ref_base),
    .busy(busy), .done(done),
    .cur_rd_en(cur_rd_en), .cur_rd_addr(cur_rd_addr), .cur_rd_data(cur_rd_data),
    .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
    .mc_src_valid(mc_src_valid), .mc_src_ready(mc_src_ready),
    .mc_curr_mb(mc_curr_mb), .mc_ref_frame(mc_ref_frame),
    .mc_dst_valid(mc_dst_valid), .mc_dst_ready(mc_dst_ready), .mc_residual(mc_residual),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_last(res_last)
  );

  typedef struct { logic [DW-1:0] data; int row; bit last; } exp_t;
  typedef struct { int ca; int ra; } addr_t;

  exp_t          exp_q[$];
  addr_t         addr_q[$];
  logic [DW-1:0] cur_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int rows_out = 0;
  bit bp_en = 0;
  bit noise = 0;
  int src_hold_amt = 0, res_hold_amt = 0;
  int src_held = 0, res_held = 0;

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pack4(input int p0, input int p1, input int p2, input int p3);
    logic [7:0] b0, b1, b2, b3;
    b0 = p0[7:0]; b1 = p1[7:0]; b2 = p2[7:0]; b3 = p3[7:0];
    return {b3, b2, b1, b0};
  endfunction

  // Per-pixel wrap-around difference cur - ref.
  function automatic logic [DW-1:0] row_diff(input logic [DW-1:0] c, input logic [DW-1:0] r);
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = c[8*i +: 8] - r[8*i +: 8];
    return d;
  endfunction

  task automatic push_model(input int cb, input int rb);
    exp_t e;
    for (int r = 0; r < NROW; r++) begin
      e.data = row_diff(cur_mem[(cb + r) % DEPTH], ref_mem[(rb + r) % DEPTH]);
      e.row  = r;
      e.last = (r == NROW - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ctl"}, {busy, done, cur_rd_en, ref_rd_en, mc_src_valid, mc_dst_ready, res_valid, res_last}, 0);
    chk({nm, "_addr"}, {cur_rd_addr, ref_rd_addr}, 0);
    chk({nm, "_data"}, {mc_curr_mb, mc_ref_frame, res_data, res_row}, 0);
  endtask

  // Memories, datapath model and ready generation. Inputs change 1 time unit
  // after the rising edge, based on what was seen at the preceding falling edge.
  initial begin
    bit            rd_pend, src_fire, dst_fire, dp_pend;
    int            rd_ca, rd_ra;
    logic [DW-1:0] src_c, src_r, dp_res;
    dp_pend = 0; dp_res = '0;
    mc_src_ready = 0; res_ready = 0; mc_dst_valid = 0; mc_residual = '0;
    cur_rd_data = '0; ref_rd_data = '0;
    forever begin
      @(negedge clk);
      rd_pend  = cur_rd_en;
      rd_ca    = int'(cur_rd_addr);
      rd_ra    = int'(ref_rd_addr);
      src_fire = mc_src_valid && mc_src_ready;
      src_c    = mc_curr_mb;
      src_r    = mc_ref_frame;
      dst_fire = mc_dst_valid && mc_dst_ready;
      @(posedge clk);
      #1;
      cur_rd_data = rd_pend ? cur_mem[rd_ca] : $urandom();
      ref_rd_data = rd_pend ? ref_mem[rd_ra] : $urandom();
      if (!reset) dp_pend = 0;
      else if (src_fire) begin
        dp_pend = 1;
        dp_res  = row_diff(src_c, src_r);
      end else if (dst_fire) dp_pend = 0;
      mc_dst_valid = dp_pend || (noise && ($urandom_range(0, 3) == 0));
      mc_residual  = dp_pend ? dp_res : $urandom();
      mc_src_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mc_src_valid && (src_held < src_hold_amt)) begin
        mc_src_ready = 1'b0;
        src_held++;
      end
      res_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (res_valid && (res_row == 2'd1) && (res_held < res_hold_amt)) begin
        res_ready = 1'b0;
        res_held++;
      end
    end
  end

  // Monitor: protocol checks, read-address scoreboard and residual scoreboard.
  initial begin
    bit            prev_sv = 0, prev_sf = 0, prev_rv = 0, prev_rf = 0, prev_done = 0;
    logic [2*DW-1:0] prev_src = '0;
    logic [DW+2:0]   prev_res = '0;
    exp_t          e;
    addr_t         a;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_sv = 0; prev_sf = 0; prev_rv = 0; prev_rf = 0; prev_done = 0;
      end else begin
        if (busy) chk("src_dst_exclusive", mc_src_valid & mc_dst_ready, 0);
        if (prev_sv && !prev_sf) begin
          chk("src_valid_held", mc_src_valid, 1);
          chk("src_data_stable", {mc_curr_mb, mc_ref_frame}, prev_src);
        end
        if (prev_rv && !prev_rf) begin
          chk("res_valid_held", res_valid, 1);
          chk("res_data_stable", {res_data, res_row, res_last}, prev_res);
        end
        if (cur_rd_en || ref_rd_en) begin
          chk("rd_en_pair", cur_rd_en, ref_rd_en);
          chk("rd_while_res_pending", res_valid, 0);
          chk("rd_expected", addr_q.size() != 0, 1);
          if (addr_q.size() != 0) begin
            a = addr_q.pop_front();
            chk("cur_rd_addr", cur_rd_addr, a.ca);
            chk("ref_rd_addr", ref_rd_addr, a.ra);
          end
        end
        if (res_valid && res_ready) begin
          rows_out++;
          chk("res_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_row", res_row, e.row);
            chk("res_last", res_last, e.last);
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_one_cycle", prev_done, 0);
        end
        prev_sv   = mc_src_valid;
        prev_sf   = mc_src_valid && mc_src_ready;
        prev_src  = {mc_curr_mb, mc_ref_frame};
        prev_rv   = res_valid;
        prev_rf   = res_valid && res_ready;
        prev_res  = {res_data, res_row, res_last};
        prev_done = done;
      end
    end
  end

  // Runs one macroblock from the current falling edge; expectations for the
  // residual rows are pushed by the caller.
  task automatic run_mb(input int cb, input int rb, input bit poke_start, output int cycles);
    int  d0, r0;
    bit  got, poked;
    addr_t a;
    for (int r = 0; r < NROW; r++) begin
      a.ca = (cb + r) % DEPTH;
      a.ra = (rb + r) % DEPTH;
      addr_q.push_back(a);
    end
    d0 = done_cnt; r0 = rows_out; got = 0; poked = 0; cycles = 0;
    cur_base = cb[AW-1:0];
    ref_base = rb[AW-1:0];
    start = 1'b1;
    while (!got && cycles < 600) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (poke_start && !poked && (rows_out - r0 == 2)) begin
        start = 1'b1;
        cur_base = AW'($urandom());
        ref_base = AW'($urandom());
        poked = 1;
      end
      if (done) got = 1;
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    chk("busy_at_done", busy, 0);
    repeat (4) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("rows_emitted", rows_out - r0, NROW);
    chk("sb_drained", exp_q.size(), 0);
    chk("rd_drained", addr_q.size(), 0);
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    int   cyc, r0, dc, waited;
    exp_t e;
    reset = 1'b0; start = 1'b0; cur_base = '0; ref_base = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cur_mem[i] = $urandom();
      ref_mem[i] = $urandom();
    end

    // Reset and idle.
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b1;
    begin
      bit idle_bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (busy || cur_rd_en || ref_rd_en || done) idle_bad = 1;
      end
      chk("idle_no_activity", idle_bad, 0);
    end

    // Directed macroblock with known rows, no backpressure.
    ref_mem[200] = pack4(55, 23, 1, 2);   cur_mem[100] = pack4(60, 30, 5, 10);
    ref_mem[201] = pack4(10, 15, 20, 25); cur_mem[101] = pack4(15, 20, 25, 30);
    ref_mem[202] = pack4(30, 35, 40, 45); cur_mem[102] = pack4(35, 40, 45, 50);
    ref_mem[203] = pack4(50, 55, 60, 65); cur_mem[103] = pack4(55, 60, 65, 70);
    for (int r = 0; r < NROW; r++) begin
      e.data = (r == 0) ? pack4(5, 7, 4, 8) : pack4(5, 5, 5, 5);
      e.row  = r;
      e.last = (r == NROW - 1);
      exp_q.push_back(e);
    end
    run_mb(100, 200, 0, cyc);
    chk("mb_latency", cyc, 21);

    // Same block with source and result stalls.
    src_hold_amt = 3;
    res_hold_amt = 4;
    push_model(100, 200);
    run_mb(100, 200, 0, cyc);
    chk("src_stall_applied", src_held, 3);
    chk("res_stall_applied", res_held, 4);
    src_hold_amt = 0;
    res_hold_amt = 0;

    // Address wrap.
    push_model(1022, 1023);
    run_mb(1022, 1023, 0, cyc);
    chk("wrap_latency", cyc, 21);

    // Second start while busy is ignored.
    push_model(300, 700);
    run_mb(300, 700, 1, cyc);

    // Reset during COLLECT of row 1.
    push_model(40, 900);
    for (int r = 0; r < NROW; r++) addr_q.push_back('{(40 + r) % DEPTH, (900 + r) % DEPTH});
    r0 = rows_out;
    cur_base = AW'(40); ref_base = AW'(900); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!((rows_out - r0 == 1) && mc_dst_ready) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("reached_collect_row1", waited < 200, 1);
    reset = 1'b0;
    #1;
    check_zero("abort");
    exp_q.delete();
    addr_q.delete();
    dc = done_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_after_abort", done_cnt - dc, 0);
    chk("idle_after_abort", busy, 0);

    // Restart after abort.
    push_model(500, 10);
    run_mb(500, 10, 0, cyc);
    chk("restart_latency", cyc, 21);

    // Randomized blocks with random stalls and stray datapath valids.
    bp_en = 1;
    noise = 1;
    for (int k = 0; k < 10; k++) begin
      int cb, rb;
      cb = int'($urandom_range(0, DEPTH - 1));
      rb = int'($urandom_range(0, DEPTH - 1));
      push_model(cb, rb);
      run_mb(cb, rb, (k == 5), cyc);
    end
    bp_en = 0;
    noise = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_row_scheduler.md
Name: mc_row_scheduler

Overview:
Sequences one macroblock through the motion_compensation residual datapath, one row at a time.
- Reads each current-MB row and its motion-shifted reference row from two line memories (1-cycle read latency).
- Presents both rows to motion_compensation over the src handshake and collects the residual over the dst handshake.
- Emits residual rows downstream through a registered valid/ready port and flags block completion.
- Sits between the ME/address-generation stage and the transform stage.

Parameters:
MB_SIZE, 4, pixels per row
PIXEL_WIDTH, 8, bits per pixel
ROWS, 4, rows per macroblock
ADDR_WIDTH, 10, line-memory address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin one macroblock (pulse or level)
cur_base  in  ADDR_WIDTH  row address of current-MB row 0
ref_base  in  ADDR_WIDTH  row address of reference row 0 (motion vector already applied)
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last row is accepted downstream
cur_rd_en  out  1  current-memory read enable
cur_rd_addr  out  ADDR_WIDTH  current-memory address
cur_rd_data  in  PIXEL_WIDTH*MB_SIZE  data, valid 1 cycle after cur_rd_en
ref_rd_en  out  1  reference-memory read enable
ref_rd_addr  out  ADDR_WIDTH  reference-memory address
ref_rd_data  in  PIXEL_WIDTH*MB_SIZE  data, valid 1 cycle after ref_rd_en
mc_src_valid  out  1  rows valid to datapath
mc_src_ready  in  1  datapath accepts rows
mc_curr_mb  out  PIXEL_WIDTH*MB_SIZE  current row to datapath
mc_ref_frame  out  PIXEL_WIDTH*MB_SIZE  reference row to datapath
mc_dst_valid  in  1  residual valid from datapath
mc_dst_ready  out  1  scheduler accepts residual
mc_residual  in  PIXEL_WIDTH*MB_SIZE  residual row
res_valid  out  1  residual row valid downstream
res_ready  in  1  downstream accepts
res_data  out  PIXEL_WIDTH*MB_SIZE  registered residual row
res_row  out  $clog2(ROWS)  row index of res_data
res_last  out  1  res_data is row ROWS-1

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, row=0. All outputs 0, including the data and address registers.
- FSM states: IDLE, READ, CAPTURE, ISSUE, COLLECT, OUTPUT, DONE.
- IDLE: on start=1, latch cur_base and ref_base, set row=0 and busy=1, go to READ. start is ignored in every other state.
- READ (1 cycle): assert cur_rd_en=ref_rd_en=1.
  - cur_rd_addr = cur_base+row; ref_rd_addr = ref_base+row.
  - Additions are modulo 2^ADDR_WIDTH (wrap, no error).
  - Go to CAPTURE.
- CAPTURE (1 cycle): register rd_data into mc_curr_mb and mc_ref_frame; go to ISSUE.
- ISSUE: mc_src_valid=1, with data held stable until mc_src_ready=1 on a rising edge. Then drop mc_src_valid and go to COLLECT.
- COLLECT: mc_dst_ready=1. On mc_dst_valid=1:
  - register mc_residual into res_data, row into res_row, and (row==ROWS-1) into res_last;
  - go to OUTPUT.
- OUTPUT: res_valid=1, with data held stable until res_ready=1.
  - On acceptance: if res_last, go to DONE; else row+1 and go to READ.
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE.
- Only one row is in flight at a time; mc_src_valid and mc_dst_ready are never asserted in the same cycle.
- Latency per row, with no backpressure: 5 cycles (READ, CAPTURE, ISSUE, COLLECT, OUTPUT). A full MB takes ROWS*5+1 cycles from start to done.
- mc_dst_valid outside COLLECT is ignored. mc_src_ready outside ISSUE is ignored.
- Asynchronous reset mid-block aborts immediately: no done pulse, all outputs 0.
- Residual is passed unchanged; widths are equal, so no truncation or sign handling is performed here.

Decomposition:
- Package mc_pkg: the state enum type, plus constants MB_SIZE, PIXEL_WIDTH, ROWS, and ROW_W = $clog2(ROWS).
- Sub-module mc_row_skid: one-entry output register holding res_data, res_row and res_last with the valid/ready handshake. Everything else lives in the top FSM.

Test Plan:
- Bench setup: datapath model responds 1 cycle after src with residual = per-pixel cur−ref.
- Reset then idle: all outputs 0; start held low for 20 cycles -> busy=0, no rd_en asserted.
- Single MB, no backpressure:
  - memory rows: ref {55,23,1,2},{10,15,20,25},{30,35,40,45},{50,55,60,65}; cur {60,30,5,10},{15,20,25,30},{35,40,45,50},{55,60,65,70};
  - expect res_data {5,7,4,8}, then {5,5,5,5} ×3;
  - res_row 0..3, res_last only on row 3, done exactly 21 cycles after start.
- Backpressure:
  - mc_src_ready low 3 cycles -> mc_curr_mb/mc_ref_frame stable, no extra reads;
  - res_ready low 4 cycles on row 1 -> res_data stays {5,5,5,5}, no READ for row 2 until accepted.
- Address wrap: cur_base=1022, ref_base=1023, ADDR_WIDTH=10 -> cur addresses 1022,1023,0,1; ref addresses 1023,0,1,2.
- Start ignored while busy, plus reset mid-block:
  - a second start pulse on row 2 -> no restart, single done pulse;
  - a separate run with reset asserted during COLLECT of row 1 -> outputs 0 immediately, no done pulse;
  - a new start after reset completes normally.
